// File: rtl/seg_pkg.sv
// Purpose : shared types, constants and the hex-to-segment decoder for the scan controller.
// Latency : n/a (types and a pure combinational function).
// Backpressure: n/a.
package seg_pkg;

    // Scan FSM states: blank, dead time at slot start, digit lit.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEAD = 2'd1,
        ON   = 2'd2
    } state_t;

    // All segments dark (active-low lines).
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] hex_to_seg_n(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Purpose : bundles the display-data inputs and the decoder/segment outputs of the scan controller.
// Latency : n/a (wires only).
// Backpressure: none; the controller accepts scan_en and load every cycle.
// Ports   : slave = controller side (takes scan_en/load/value/dp/blank_mask, drives
//           sel_a/sel_b/dec_en/seg_n/dp_n/frame_tick); master = the opposite side.
interface seg_scan_ctrl_if;
    logic        scan_en;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank_mask;
    logic        sel_a;
    logic        sel_b;
    logic        dec_en;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic        frame_tick;

    modport master (
        output scan_en, load, value, dp, blank_mask,
        input  sel_a, sel_b, dec_en, seg_n, dp_n, frame_tick
    );

    modport slave (
        input  scan_en, load, value, dp, blank_mask,
        output sel_a, sel_b, dec_en, seg_n, dp_n, frame_tick
    );
endinterface

// File: rtl/seg_prescaler.sv
// Purpose : per-slot clock counter, 0..PRESCALE-1, flagging end of dead time and end of slot.
// Latency : flags are decoded from the registered count (same cycle as the count value).
// Backpressure: none; clear holds the count at 0.
// Ports   : clk, rst_n (async active-low), clear in; dead_done (count == DEAD-1),
//           slot_done (count == PRESCALE-1) out.
module seg_prescaler #(
    parameter int PRESCALE = 1000,
    parameter int DEAD     = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic dead_done,
    output logic slot_done
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q;

    assign dead_done = (cnt_q == DEAD_LAST);
    assign slot_done = (cnt_q == SLOT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear || slot_done) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Purpose : four-digit seven-segment scanner with dead time and double-buffered display data.
// Latency : first slot (digit 0, frame_tick) one clock after scan_en is sampled high; dec_en DEAD clocks later.
// Backpressure: none; a load is always captured, a second load before transfer overwrites the first.
// Ports   : clk, rst_n (async active-low); bus.slave carries scan_en, load, value[15:0], dp[3:0],
//           blank_mask[3:0] in and sel_a, sel_b, dec_en, seg_n[6:0], dp_n, frame_tick out (all registered).
module seg_scan_ctrl #(
    parameter int PRESCALE = 1000,
    parameter int DEAD     = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    seg_scan_ctrl_if.slave bus
);

    import seg_pkg::*;

    state_t      state_q, state_d;
    logic [1:0]  digit_q, digit_d;
    logic        slot_start;
    logic        xfer;
    logic        cnt_clear, dead_done, slot_done;

    logic [15:0] act_value_q, pend_value_q, nxt_value;
    logic [3:0]  act_dp_q, pend_dp_q, nxt_dp;
    logic [3:0]  act_mask_q, pend_mask_q, nxt_mask;
    logic        pend_vld_q;

    logic [1:0]  sel_q, sel_d;
    logic        dec_en_q, dec_en_d;
    logic [6:0]  seg_n_q, seg_n_d;
    logic        dp_n_q, dp_n_d;
    logic        frame_q, frame_d;

    // Counter restarts from 0 on the first clock after leaving IDLE.
    assign cnt_clear = (state_q == seg_pkg::IDLE) || !bus.scan_en;

    seg_prescaler #(
        .PRESCALE (PRESCALE),
        .DEAD     (DEAD)
    ) u_prescaler (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (cnt_clear),
        .dead_done (dead_done),
        .slot_done (slot_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= seg_pkg::IDLE;
            digit_q <= 2'd0;
        end else begin
            state_q <= state_d;
            digit_q <= digit_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        digit_d    = digit_q;
        slot_start = 1'b0;
        xfer       = 1'b0;
        sel_d      = sel_q;
        dec_en_d   = dec_en_q;
        seg_n_d    = seg_n_q;
        dp_n_d     = dp_n_q;
        frame_d    = 1'b0;
        nxt_value  = act_value_q;
        nxt_dp     = act_dp_q;
        nxt_mask   = act_mask_q;

        case (state_q)
            seg_pkg::IDLE: begin
                if (bus.scan_en) begin
                    state_d    = seg_pkg::DEAD;
                    digit_d    = 2'd0;
                    slot_start = 1'b1;
                end
            end
            seg_pkg::DEAD: begin
                if (dead_done) begin
                    state_d  = seg_pkg::ON;
                    dec_en_d = ~act_mask_q[digit_q];
                end
            end
            seg_pkg::ON: begin
                if (slot_done) begin
                    state_d    = seg_pkg::DEAD;
                    digit_d    = digit_q + 2'd1;
                    slot_start = 1'b1;
                end
            end
            default: state_d = seg_pkg::IDLE;
        endcase

        // Frame boundary: new data goes live here, a coincident load wins over pending.
        xfer = slot_start && (digit_d == 2'd0);
        if (xfer && bus.load) begin
            nxt_value = bus.value;
            nxt_dp    = bus.dp;
            nxt_mask  = bus.blank_mask;
        end else if (xfer && pend_vld_q) begin
            nxt_value = pend_value_q;
            nxt_dp    = pend_dp_q;
            nxt_mask  = pend_mask_q;
        end

        // Select and segment lines change only while the decoder is disabled.
        if (slot_start) begin
            frame_d  = xfer;
            sel_d    = digit_d;
            dec_en_d = 1'b0;
            seg_n_d  = nxt_mask[digit_d] ? SEG_BLANK
                                         : hex_to_seg_n(nxt_value[{digit_d, 2'b00} +: 4]);
            dp_n_d   = ~nxt_dp[digit_d];
        end

        if (!bus.scan_en) begin
            state_d    = seg_pkg::IDLE;
            digit_d    = 2'd0;
            slot_start = 1'b0;
            xfer       = 1'b0;
            sel_d      = 2'd0;
            dec_en_d   = 1'b0;
            seg_n_d    = SEG_BLANK;
            dp_n_d     = 1'b1;
            frame_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q    <= 2'd0;
            dec_en_q <= 1'b0;
            seg_n_q  <= SEG_BLANK;
            dp_n_q   <= 1'b1;
            frame_q  <= 1'b0;
        end else begin
            sel_q    <= sel_d;
            dec_en_q <= dec_en_d;
            seg_n_q  <= seg_n_d;
            dp_n_q   <= dp_n_d;
            frame_q  <= frame_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_value_q  <= 16'd0;
            act_dp_q     <= 4'd0;
            act_mask_q   <= 4'd0;
            pend_value_q <= 16'd0;
            pend_dp_q    <= 4'd0;
            pend_mask_q  <= 4'd0;
            pend_vld_q   <= 1'b0;
        end else if (xfer) begin
            act_value_q <= nxt_value;
            act_dp_q    <= nxt_dp;
            act_mask_q  <= nxt_mask;
            pend_vld_q  <= 1'b0;
        end else if (bus.load) begin
            pend_value_q <= bus.value;
            pend_dp_q    <= bus.dp;
            pend_mask_q  <= bus.blank_mask;
            pend_vld_q   <= 1'b1;
        end
    end

    assign bus.sel_a      = sel_q[1];
    assign bus.sel_b      = sel_q[0];
    assign bus.dec_en     = dec_en_q;
    assign bus.seg_n      = seg_n_q;
    assign bus.dp_n       = dp_n_q;
    assign bus.frame_tick = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Purpose : self-checking bench for seg_scan_ctrl with PRESCALE=8, DEAD=2.
// Latency : expected slots are queued as stimulus is applied and compared clock by clock.
// Backpressure: n/a.
module tb_seg_scan_ctrl;

    localparam int P = 8;
    localparam int D = 2;
    // {sel_a, sel_b, dec_en, seg_n, dp_n, frame_tick} when blank
    localparam logic [11:0] BLANK_V = {2'b00, 1'b0, 7'h7F, 1'b1, 1'b0};

    typedef struct packed {
        logic [1:0] sel;
        logic [6:0] seg;
        logic       dp_n;
        logic       frame;
        logic       on;
    } slot_t;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    slot_t sb_q[$];

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    seg_scan_ctrl_if bus ();

    seg_scan_ctrl #(
        .PRESCALE (P),
        .DEAD     (D)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [11:0] obs();
        return {bus.sel_a, bus.sel_b, bus.dec_en, bus.seg_n, bus.dp_n, bus.frame_tick};
    endfunction

    task automatic push_slots(input logic [15:0] v, input logic [3:0] d,
                              input logic [3:0] m, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            slot_t      s;
            logic [3:0] nib;
            nib     = v[i*4 +: 4];
            s.sel   = 2'(i);
            s.seg   = m[i] ? 7'h7F : seg_tab[nib];
            s.dp_n  = ~d[i];
            s.frame = (i == 0);
            s.on    = ~m[i];
            sb_q.push_back(s);
        end
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] m);
        bus.load       = 1'b1;
        bus.value      = v;
        bus.dp         = d;
        bus.blank_mask = m;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    // Entered at the negedge of the first clock of a slot; leaves at the first clock of the next.
    task automatic drain_slots(input int n, input string tag);
        for (int s = 0; s < n; s++) begin
            slot_t e;
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL %s: scoreboard empty at slot %0d", tag, s);
                return;
            end
            e = sb_q.pop_front();
            for (int k = 0; k < P; k++) begin
                logic [11:0] got;
                logic [11:0] exp;
                got = obs();
                exp = {e.sel, (k >= D) ? e.on : 1'b0, e.seg, e.dp_n, (k == 0) ? e.frame : 1'b0};
                vectors++;
                if (got !== exp) begin
                    miscompares++;
                    $display("FAIL %s slot %0d clk %0d: got sel=%b en=%b seg=%b dp_n=%b tick=%b, want sel=%b en=%b seg=%b dp_n=%b tick=%b",
                             tag, s, k, got[11:10], got[9], got[8:2], got[1], got[0],
                             exp[11:10], exp[9], exp[8:2], exp[1], exp[0]);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.scan_en    = 1'b0;
        bus.load       = 1'b0;
        bus.value      = 16'd0;
        bus.dp         = 4'd0;
        bus.blank_mask = 4'd0;
        repeat (2) @(negedge clk);
        vectors++;
        if (obs() !== BLANK_V) begin
            miscompares++;
            $display("FAIL reset_hold: got %h want %h", obs(), BLANK_V);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vectors++;
            if (obs() !== BLANK_V) begin
                miscompares++;
                $display("FAIL idle_after_reset clk %0d: got %h want %h", i, obs(), BLANK_V);
            end
        end
    endtask

    task automatic test_scan();
        pulse_load(16'h8F10, 4'b0100, 4'b0000);
        bus.scan_en = 1'b1;
        push_slots(16'h8F10, 4'b0100, 4'b0000, 0, 3);
        push_slots(16'h8F10, 4'b0100, 4'b0000, 0, 3);
        @(negedge clk);
        drain_slots(8, "scan");
    endtask

    task automatic test_midframe_load();
        push_slots(16'h8F10, 4'b0100, 4'b0000, 0, 3);
        drain_slots(1, "mid_pre");
        fork
            pulse_load(16'h1234, 4'b0000, 4'b0000);
        join_none
        push_slots(16'h1234, 4'b0000, 4'b0000, 0, 3);
        drain_slots(7, "mid_load");
    endtask

    // Load lands on the very clock that opens digit 0, so it goes live without waiting a frame.
    task automatic test_blank_mask();
        fork
            begin
                repeat (4*P - 1) @(negedge clk);
                pulse_load(16'hABCD, 4'b0001, 4'b1010);
            end
        join_none
        push_slots(16'h1234, 4'b0000, 4'b0000, 0, 3);
        push_slots(16'hABCD, 4'b0001, 4'b1010, 0, 3);
        drain_slots(8, "mask");
    endtask

    task automatic test_scan_drop();
        push_slots(16'hABCD, 4'b0001, 4'b1010, 0, 1);
        drain_slots(2, "drop_pre");
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.dec_en !== 1'b1) begin
            miscompares++;
            $display("FAIL drop_on_phase: got dec_en=%b want 1", bus.dec_en);
        end
        bus.scan_en = 1'b0;
        @(negedge clk);
        vectors++;
        if (obs() !== BLANK_V) begin
            miscompares++;
            $display("FAIL drop_blank: got %h want %h", obs(), BLANK_V);
        end
        pulse_load(16'h5A0E, 4'b0000, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (obs() !== BLANK_V) begin
                miscompares++;
                $display("FAIL drop_idle clk %0d: got %h want %h", i, obs(), BLANK_V);
            end
            @(negedge clk);
        end
        bus.scan_en = 1'b1;
        push_slots(16'h5A0E, 4'b0000, 4'b0000, 0, 3);
        @(negedge clk);
        drain_slots(4, "restart");
    endtask

    task automatic test_async_reset();
        pulse_load(16'h7777, 4'b1111, 4'b0000);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (obs() !== BLANK_V) begin
            miscompares++;
            $display("FAIL async_reset: got %h want %h", obs(), BLANK_V);
        end
        @(negedge clk);
        bus.scan_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (obs() !== BLANK_V) begin
            miscompares++;
            $display("FAIL post_reset_idle: got %h want %h", obs(), BLANK_V);
        end
        bus.scan_en = 1'b1;
        push_slots(16'h0000, 4'b0000, 4'b0000, 0, 3);
        @(negedge clk);
        drain_slots(4, "post_reset");
        bus.scan_en = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_scan();
        test_midframe_load();
        test_blank_mask();
        test_scan_drop();
        test_async_reset();
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_left: got %0d entries want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Four-digit seven-segment scan controller feeding the 2-to-4 active-low digit decoder.
- Time-multiplexes a 16-bit hex value across four digits: drives the decoder select pair (A, B) and enable, plus active-low segment and decimal-point lines.
- Dead time before each digit suppresses ghosting; double-buffered display data gives tear-free frame updates.

Parameters:
- PRESCALE, 1000, clocks per digit slot; legal range PRESCALE >= DEAD + 2.
- DEAD, 16, clocks at the start of each slot with dec_en low; legal range DEAD >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- scan_en  in  1  scanning enable; 0 blanks the display.
- load  in  1  single-cycle strobe that captures value, dp, and blank_mask.
- value  in  16  four hex nibbles; digit d uses value[4d+3:4d].
- dp  in  4  decimal point per digit, 1 = lit.
- blank_mask  in  4  1 = digit d kept dark for the whole slot.
- sel_a  out  1  decoder A input (MSB of the digit index).
- sel_b  out  1  decoder B input (LSB of the digit index).
- dec_en  out  1  decoder enable, active high.
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_n  out  1  decimal point, active-low.
- frame_tick  out  1  one-clock pulse at the start of each digit-0 slot.

Behaviour:
- One clock domain; reset is asynchronous and active-low (rst_n). All outputs are registered.
- Reset values:
  - state IDLE, prescale counter 0, digit index 0.
  - sel_a = 0, sel_b = 0, dec_en = 0, seg_n = 7'h7F, dp_n = 1, frame_tick = 0.
  - Active and pending registers = 0; pending_valid = 0.
- Reset asserted mid-operation forces the reset values immediately, with no completion of the current slot.
- States:
  - IDLE: outputs blank (dec_en 0, seg_n 7'h7F, dp_n 1).
  - DEAD: first DEAD clocks of a slot.
  - ON: remaining PRESCALE - DEAD clocks of a slot.
- Transitions:
  - IDLE to DEAD when scan_en = 1, starting at digit 0.
  - DEAD to ON when the counter reaches DEAD - 1.
  - ON to DEAD when the counter reaches PRESCALE - 1; the counter wraps to 0 and the digit index increments mod 4 (3 wraps to 0).
  - Any state to IDLE on the clock after scan_en = 0. The counter and digit index are cleared; pending data is retained.
- Latency: scan_en rises at edge t. Then at edge t+1: DEAD, digit 0, sel = 00, frame_tick = 1. At edge t+1+DEAD: dec_en = 1.
- Slot update:
  - sel_a/sel_b, seg_n, and dp_n update on the first DEAD clock of each slot, while dec_en = 0.
  - They are stable throughout the ON phase.
- In ON, dec_en = 1 unless active blank_mask[d] = 1. A blanked digit keeps dec_en = 0 and seg_n = 7'h7F.
- Segment encoding (active-low gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- dp_n = ~active dp[d].
- Double buffering:
  - load writes the pending registers and sets pending_valid. A second load before transfer overwrites the pending data.
  - Transfer pending to active happens only on the first clock of a digit-0 slot, then clears pending_valid.
  - If load coincides with that clock, the incoming load data transfers directly and pending_valid stays 0.
- frame_tick pulses only on digit-0 slot starts, including the first slot after leaving IDLE.

Decomposition:
- Shared package seg_pkg:
  - state enum {IDLE, DEAD, ON};
  - constant SEG_BLANK = 7'h7F;
  - function hex_to_seg_n(nibble) returning the table above.
- Sub-module seg_prescaler: parameterised PRESCALE counter with clear input and outputs dead_done and slot_done. The FSM, digit counter, and buffers stay in the top.

Test Plan (PRESCALE=8, DEAD=2):
- Reset release with scan_en = 0 → dec_en = 0, seg_n = 7F, dp_n = 1, sel = 00 indefinitely; no frame_tick.
- load value=16'h8F10, dp=4'b0100, mask=0; scan_en=1 → digit sequence:
  - sel 00: seg 1000000;
  - sel 01: seg 1111001;
  - sel 10: seg 0001110, dp_n = 0;
  - sel 11: seg 0000000.
  - Each slot: dec_en 0 for 2 clocks, then 1 for 6; frame_tick every 32 clocks.
- load 16'h1234 mid-frame (during digit 1) → digits 2 and 3 still show old data; new data appears at the next frame_tick, in the same cycle as the pulse.
- blank_mask = 4'b1010 → dec_en never 1 during the digit-1 and digit-3 slots; slot timing unchanged.
- scan_en dropped during the ON phase of digit 2 → the next clock is blank and IDLE. On reassert: digit 0 restarts with frame_tick and dead time first.
- rst_n asserted asynchronously mid-slot → outputs take reset values before the next clock edge; pending load is discarded.
